uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Control and buffering stage for the UART receive path.
- Enables the receiver and programs its parity select.
- Captures each completed frame (data plus parity/stop error bits) into a DEPTH-entry first-word-fall-through FIFO.
- Presents captured frames to the host over a valid/ready interface.
- Keeps sticky overrun/error status and raises an idle-line interrupt after a quiet gap.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
IDLE_TICKS, 160, baud_tick count of line silence after the last byte before idle_irq
CNT_W, 8, idle counter width; must hold IDLE_TICKS-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
baud_tick  input  1  one-cycle baud strobe from the baud tick generator
cfg_we  input  1  config write strobe
cfg_wdata  input  3  [0]=enable, [1]=parity select, [2]=clear status (self-clearing)
rx_busy  input  1  receiver is mid-frame
rx_done  input  1  one-cycle strobe: frame complete
rx_data  input  8  received byte, valid with rx_done
rx_p_error  input  1  parity error, valid with rx_done
rx_stop_error  input  1  stop-bit error, valid with rx_done
rx_en  output  1  receiver enable
p_sel  output  1  parity select driven to the receiver
m_valid  output  1  FIFO head valid
m_data  output  8  FIFO head byte
m_err  output  2  FIFO head errors {stop, parity}
m_ready  input  1  host accepts head
fifo_count  output  log2(DEPTH)+1  occupancy
overrun  output  1  sticky: byte dropped because FIFO was full
err_sticky  output  1  sticky: an accepted byte carried an error
idle_irq  output  1  one-cycle pulse on idle-line detection
state  output  2  0=OFF, 1=RUN, 2=DRAIN

Behaviour:
- Reset (sync, high): state=OFF, rx_en=0, p_sel=0, FIFO emptied (contents discarded), fifo_count=0, m_valid=0, m_data=0, m_err=0, overrun=0, err_sticky=0, idle_irq=0, idle counter=0, disarmed. Reset mid-frame discards everything; no partial push.
- FSM, all transitions registered:
  - OFF: rx_en=0. cfg_we with enable=1 -> RUN.
  - RUN: rx_en=1. cfg_we with enable=0 -> OFF if rx_busy=0, else DRAIN.
  - DRAIN: rx_en=1; the in-flight frame is still accepted. When rx_busy=0 and rx_done=0 -> OFF. cfg_we with enable=1 -> RUN.
  - Encoding 3 is unreachable; it recovers to OFF.
- p_sel: updated from cfg_wdata[1] only when cfg_we occurs in OFF (including the write that moves OFF->RUN). Writes in RUN/DRAIN do not change it.
- Clear (cfg_wdata[2] with cfg_we): clears overrun and err_sticky in any state. Same-cycle set beats clear.
- Push: rx_done while state != OFF. rx_done in OFF is ignored.
  - Full with no pop in the same cycle: byte dropped, overrun<=1, count unchanged.
  - Full with a pop in the same cycle: push accepted, count stays DEPTH.
- Pop: m_valid && m_ready. m_valid = (count != 0). m_data/m_err reflect the head entry combinationally from FIFO storage.
- Simultaneous push and pop: count unchanged.
- Latency: push on rx_done in cycle N with FIFO empty -> m_valid=1 with that byte in cycle N+1.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- err_sticky<=1 on an accepted push where rx_p_error|rx_stop_error. Dropped bytes set only overrun.
- Idle detection:
  - Arm on an accepted push.
  - Counter clears on rx_done, on rx_busy=1, or when state != RUN.
  - While armed, RUN, and rx_busy=0, the counter increments on baud_tick.
  - When baud_tick arrives with counter == IDLE_TICKS-1: idle_irq=1 for the next cycle, counter=0, disarm.
  - A new push re-arms.

Test Plan:
- Reset; cfg_we wdata=3'b011 -> state=RUN, rx_en=1, p_sel=1. Then cfg_we wdata=3'b000 -> p_sel stays 1 (written outside OFF), and with rx_busy=0 state=OFF next cycle.
- RUN; rx_done with rx_data=8'hA5, errors 0, m_ready=0 -> m_valid=1, m_data=8'hA5, m_err=2'b00, fifo_count=1 the following cycle. Then m_ready=1 for one cycle -> m_valid=0, count=0.
- Push 5 bytes 8'h01..8'h05 with m_ready=0, DEPTH=4 -> count=4, overrun=1, drain order 01,02,03,04. Push on full with a same-cycle pop -> accepted, count stays 4.
- Push 8'h3C with rx_stop_error=1 -> m_err=2'b10, err_sticky=1. cfg_we wdata=3'b101 -> both stickies clear. Clear in the same cycle as an overrun drop -> overrun=1.
- In RUN with rx_busy=1, write enable=0 -> DRAIN. rx_done 8'h77 is pushed; rx_busy falls -> OFF. A later rx_done in OFF -> no push.
- IDLE_TICKS=4: push a byte, rx_busy=0, then 4 baud_ticks -> single idle_irq pulse after the 4th. No second pulse without a new push. A byte arriving after the 2nd tick resets the count.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive control stage: receiver enable/parity programming, a first-word-fall-through
// frame FIFO towards the host, sticky overrun/error status and an idle-line interrupt.
module uart_rx_ctrl #(
  parameter int DEPTH      = 4,
  parameter int IDLE_TICKS = 160,
  parameter int CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      baud_tick,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_wdata,
  input  logic                      rx_busy,
  input  logic                      rx_done,
  input  logic [7:0]                rx_data,
  input  logic                      rx_p_error,
  input  logic                      rx_stop_error,
  output logic                      rx_en,
  output logic                      p_sel,
  output logic                      m_valid,
  output logic [7:0]                m_data,
  output logic [1:0]                m_err,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overrun,
  output logic                      err_sticky,
  output logic                      idle_irq,
  output logic [1:0]                state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TICKS - 1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             p_sel_q, p_sel_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             err_q, err_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             idle_irq_q, idle_irq_d;
  logic [9:0]       mem_q [DEPTH];

  logic push_req, push_ok, drop, pop, full, clear;
  logic [9:0] head;

  assign full     = (count_q == FULL_CNT);
  assign m_valid  = (count_q != '0);
  assign pop      = m_valid && m_ready;
  assign push_req = rx_done && (state_q == S_RUN || state_q == S_DRAIN);
  // A full FIFO still takes the new frame when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;
  assign clear    = cfg_we && cfg_wdata[2];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   if (cfg_we && cfg_wdata[0]) state_d = S_RUN;
      S_RUN:   if (cfg_we && !cfg_wdata[0]) state_d = rx_busy ? S_DRAIN : S_OFF;
      S_DRAIN: begin
        if (cfg_we && cfg_wdata[0])     state_d = S_RUN;
        else if (!rx_busy && !rx_done)  state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    p_sel_d   = p_sel_q;
    overrun_d = overrun_q;
    err_d     = err_q;
    // Parity select is only reprogrammable while the receiver is off.
    if (cfg_we && state_q == S_OFF) p_sel_d = cfg_wdata[1];
    if (clear) begin
      overrun_d = 1'b0;
      err_d     = 1'b0;
    end
    if (drop) overrun_d = 1'b1;
    if (push_ok && (rx_p_error || rx_stop_error)) err_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    armed_d    = armed_q;
    idle_cnt_d = idle_cnt_q;
    idle_irq_d = 1'b0;
    if (rx_done || rx_busy || state_q != S_RUN) begin
      idle_cnt_d = '0;
    end else if (armed_q && baud_tick) begin
      if (idle_cnt_q == IDLE_LAST) begin
        idle_irq_d = 1'b1;
        idle_cnt_d = '0;
        armed_d    = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
    if (push_ok) armed_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_OFF;
      p_sel_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      idle_cnt_q <= '0;
      idle_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_sel_q    <= p_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      idle_cnt_q <= idle_cnt_d;
      idle_irq_q <= idle_irq_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because the
  // head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= {rx_stop_error, rx_p_error, rx_data};
  end

  assign head       = mem_q[rd_ptr_q];
  assign m_data     = m_valid ? head[7:0] : 8'h00;
  assign m_err      = m_valid ? head[9:8] : 2'b00;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign err_sticky = err_q;
  assign idle_irq   = idle_irq_q;
  assign p_sel      = p_sel_q;
  assign state      = state_q;
  assign rx_en      = (state_q == S_RUN) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed vector table, hand sequences for drain and idle-line
// behaviour, and a randomized run against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int IDLE  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick, cfg_we, rx_busy, rx_done, rx_p_error, rx_stop_error, m_ready;
  logic [2:0] cfg_wdata;
  logic [7:0] rx_data;
  logic       rx_en, p_sel, m_valid, overrun, err_sticky, idle_irq;
  logic [7:0] m_data;
  logic [1:0] m_err, state;
  logic [2:0] fifo_count;

  uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_TICKS(IDLE), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .rx_busy(rx_busy), .rx_done(rx_done), .rx_data(rx_data), .rx_p_error(rx_p_error),
    .rx_stop_error(rx_stop_error), .rx_en(rx_en), .p_sel(p_sel), .m_valid(m_valid),
    .m_data(m_data), .m_err(m_err), .m_ready(m_ready), .fifo_count(fifo_count),
    .overrun(overrun), .err_sticky(err_sticky), .idle_irq(idle_irq), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       we;
    bit [2:0] wd;
    bit       busy;
    bit       done;
    bit [7:0] d;
    bit       pe;
    bit       se;
    bit       rdy;
    bit       tick;
  } in_t;

  typedef struct {
    in_t      i;
    int       st;
    int       cnt;
    bit       vld;
    bit [7:0] dat;
    bit [1:0] merr;
    bit       ovr;
    bit       errs;
    bit       psel;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: frames held in a queue, status as plain flags.
  int         md_st;
  bit         md_psel, md_ovr, md_errs, md_irq, md_armed;
  int         md_ticks;
  logic [9:0] md_q[$];

  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk_in(bit we, bit [2:0] wd, bit busy, bit done, bit [7:0] d,
                                bit pe, bit se, bit rdy, bit tick);
    in_t r;
    r.we = we; r.wd = wd; r.busy = busy; r.done = done; r.d = d;
    r.pe = pe; r.se = se; r.rdy = rdy; r.tick = tick;
    return r;
  endfunction

  function automatic void add(bit we, bit [2:0] wd, bit busy, bit done, bit [7:0] d, bit pe,
                              bit se, bit rdy, int st, int cnt, bit vld, bit [7:0] dat,
                              bit [1:0] merr, bit ovr, bit errs, bit psel);
    vec_t v;
    v.i = mk_in(we, wd, busy, done, d, pe, se, rdy, 1'b0);
    v.st = st; v.cnt = cnt; v.vld = vld; v.dat = dat; v.merr = merr;
    v.ovr = ovr; v.errs = errs; v.psel = psel;
    tbl.push_back(v);
  endfunction

  function automatic void model_reset();
    md_st = 0; md_psel = 0; md_ovr = 0; md_errs = 0; md_irq = 0; md_armed = 0; md_ticks = 0;
    md_q.delete();
  endfunction

  function automatic void model_step(in_t i);
    bit pop, push, accept;
    int nst;
    pop    = (md_q.size() != 0) && i.rdy;
    push   = i.done && (md_st != 0);
    accept = push && ((md_q.size() < DEPTH) || pop);
    nst    = md_st;
    if (md_st == 0) begin
      if (i.we && i.wd[0]) nst = 1;
      if (i.we) md_psel = i.wd[1];
    end else if (md_st == 1) begin
      if (i.we && !i.wd[0]) nst = i.busy ? 2 : 0;
    end else begin
      if (i.we && i.wd[0]) nst = 1;
      else if (!i.busy && !i.done) nst = 0;
    end
    if (i.we && i.wd[2]) begin md_ovr = 0; md_errs = 0; end
    if (push && !accept) md_ovr = 1;
    if (accept && (i.pe || i.se)) md_errs = 1;
    md_irq = 0;
    if (i.done || i.busy || md_st != 1) md_ticks = 0;
    else if (md_armed && i.tick) begin
      md_ticks++;
      if (md_ticks == IDLE) begin md_irq = 1; md_ticks = 0; md_armed = 0; end
    end
    if (accept) md_armed = 1;
    if (pop) void'(md_q.pop_front());
    if (accept) md_q.push_back({i.se, i.pe, i.d});
    md_st = nst;
  endfunction

  task automatic check_model();
    logic [9:0] h;
    h = (md_q.size() != 0) ? md_q[0] : 10'h0;
    check("state",      state,      md_st);
    check("rx_en",      rx_en,      int'(md_st != 0));
    check("p_sel",      p_sel,      md_psel);
    check("m_valid",    m_valid,    int'(md_q.size() != 0));
    check("m_data",     m_data,     h[7:0]);
    check("m_err",      m_err,      h[9:8]);
    check("fifo_count", fifo_count, md_q.size());
    check("overrun",    overrun,    md_ovr);
    check("err_sticky", err_sticky, md_errs);
    check("idle_irq",   idle_irq,   md_irq);
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic cyc(input in_t i);
    cfg_we = i.we; cfg_wdata = i.wd; rx_busy = i.busy; rx_done = i.done; rx_data = i.d;
    rx_p_error = i.pe; rx_stop_error = i.se; m_ready = i.rdy; baud_tick = i.tick;
    model_step(i);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_we = 0; cfg_wdata = 0; rx_busy = 0; rx_done = 0; rx_data = 0;
    rx_p_error = 0; rx_stop_error = 0; m_ready = 0; baud_tick = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic tick_expect(input string nm, input bit exp_irq);
    cyc(mk_in(0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 1));
    check(nm, idle_irq, exp_irq);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("reset.state", state, 0);
    check("reset.count", fifo_count, 0);
    check("reset.valid", m_valid, 0);
    check("reset.data",  m_data, 0);
    check("reset.rx_en", rx_en, 0);
    check("reset.irq",   idle_irq, 0);

    //  we  wd      bsy dn data  pe se rdy  st cnt vld dat   merr   ovr err psel
    add(1, 3'b011, 0, 0, 8'h00, 0, 0, 0,  1, 0, 0, 8'h00, 2'b00, 0, 0, 1);
    add(1, 3'b000, 0, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h00, 2'b00, 0, 0, 1);
    add(1, 3'b001, 0, 0, 8'h00, 0, 0, 0,  1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'hA5, 0, 0, 0,  1, 1, 1, 8'hA5, 2'b00, 0, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'h01, 0, 0, 0,  1, 1, 1, 8'h01, 2'b00, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'h02, 0, 0, 0,  1, 2, 1, 8'h01, 2'b00, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'h03, 0, 0, 0,  1, 3, 1, 8'h01, 2'b00, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'h04, 0, 0, 0,  1, 4, 1, 8'h01, 2'b00, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'h05, 0, 0, 0,  1, 4, 1, 8'h01, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 1, 8'h06, 0, 0, 1,  1, 4, 1, 8'h02, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 3, 1, 8'h03, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 2, 1, 8'h04, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 1, 1, 8'h06, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 0, 0, 8'h00, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 1, 8'h3C, 0, 1, 0,  1, 1, 1, 8'h3C, 2'b10, 1, 1, 0);
    add(1, 3'b111, 0, 0, 8'h00, 0, 0, 0,  1, 1, 1, 8'h3C, 2'b10, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'h10, 0, 0, 0,  1, 2, 1, 8'h3C, 2'b10, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'h11, 0, 0, 0,  1, 3, 1, 8'h3C, 2'b10, 0, 0, 0);
    add(0, 3'b000, 0, 1, 8'h12, 0, 0, 0,  1, 4, 1, 8'h3C, 2'b10, 0, 0, 0);
    add(1, 3'b101, 0, 1, 8'h13, 0, 0, 0,  1, 4, 1, 8'h3C, 2'b10, 1, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 3, 1, 8'h10, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 2, 1, 8'h11, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 1, 1, 8'h12, 2'b00, 1, 0, 0);
    add(0, 3'b000, 0, 0, 8'h00, 0, 0, 1,  1, 0, 0, 8'h00, 2'b00, 1, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].i);
      check($sformatf("vec%0d.state", k), state,      tbl[k].st);
      check($sformatf("vec%0d.count", k), fifo_count, tbl[k].cnt);
      check($sformatf("vec%0d.valid", k), m_valid,    tbl[k].vld);
      check($sformatf("vec%0d.data", k),  m_data,     tbl[k].dat);
      check($sformatf("vec%0d.err", k),   m_err,      tbl[k].merr);
      check($sformatf("vec%0d.ovr", k),   overrun,    tbl[k].ovr);
      check($sformatf("vec%0d.errs", k),  err_sticky, tbl[k].errs);
      check($sformatf("vec%0d.psel", k),  p_sel,      tbl[k].psel);
    end

    // Disable while a frame is in flight: finish the frame, then turn off.
    do_reset();
    cyc(mk_in(1, 3'b001, 0, 0, 8'h00, 0, 0, 0, 0));
    cyc(mk_in(1, 3'b000, 1, 0, 8'h00, 0, 0, 0, 0));
    check("drain.enter", state, 2);
    check("drain.rx_en", rx_en, 1);
    cyc(mk_in(0, 3'b000, 1, 0, 8'h00, 0, 0, 0, 0));
    check("drain.hold", state, 2);
    cyc(mk_in(0, 3'b000, 1, 1, 8'h77, 0, 0, 0, 0));
    check("drain.push_cnt", fifo_count, 1);
    check("drain.push_dat", m_data, 8'h77);
    check("drain.stay", state, 2);
    cyc(mk_in(0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0));
    check("drain.off", state, 0);
    cyc(mk_in(0, 3'b000, 0, 1, 8'h88, 0, 0, 0, 0));
    check("off.no_push", fifo_count, 1);
    check("off.head", m_data, 8'h77);

    // Idle-line interrupt with IDLE=4 ticks.
    do_reset();
    cyc(mk_in(1, 3'b001, 0, 0, 8'h00, 0, 0, 0, 0));
    cyc(mk_in(0, 3'b000, 0, 1, 8'h55, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) tick_expect($sformatf("idle.tick%0d", k + 1), 0);
    tick_expect("idle.pulse", 1);
    cyc(mk_in(0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0));
    check("idle.one_cycle", idle_irq, 0);
    for (int k = 0; k < 8; k++) tick_expect("idle.disarmed", 0);
    cyc(mk_in(0, 3'b000, 0, 1, 8'h56, 0, 0, 0, 0));
    tick_expect("idle.rearm1", 0);
    tick_expect("idle.rearm2", 0);
    cyc(mk_in(0, 3'b000, 0, 1, 8'h57, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) tick_expect("idle.restart", 0);
    tick_expect("idle.pulse2", 1);

    // Randomized traffic against the reference model.
    do_reset();
    begin
      bit busy_r = 0;
      for (int n = 0; n < 3000; n++) begin
        in_t r;
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
          check_model();
        end
        if ($urandom_range(0, 7) == 0) busy_r = ~busy_r;
        r = mk_in($urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)), busy_r,
                  $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) != 0) r.wd[0] = 1'b1;
        cyc(r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
